// File: rtl/ext_loader_pkg.sv
// Shared state encoding and protocol byte values for the external-memory boot loader.
package ext_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT,
        ADDR,
        DATA,
        WRITE,
        RUNNING
    } state_t;

    localparam logic [7:0] HDR_LOAD = 8'hA5;
    localparam logic [7:0] HDR_RUN  = 8'h5A;
    localparam logic [7:0] CMD_HALT = 8'hC3;

    function automatic logic state_busy(input state_t s);
        return !((s == IDLE) || (s == RUNNING));
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four bytes, LSB first, into a 32-bit little-endian word.
// word_next is the word as it will stand once the current byte is shifted in.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  din,
    output logic        full,
    output logic [31:0] word_next
);
    logic [1:0]  idx;
    logic [31:0] sr;

    assign full      = (idx == 2'd3);
    assign word_next = {din, sr[31:8]};

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx <= 2'd0;
            sr  <= 32'd0;
        end else if (shift) begin
            sr  <= word_next;
            idx <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/ext_mem_loader.sv
// Host byte-stream boot loader: parses load/run/halt frames, writes words to CPU memory.
// One write cycle per word (in_ready low for that cycle); peak 1 word per 5 cycles; all outputs registered.
module ext_mem_loader
    import ext_loader_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             Ext_MemWrite,
    output logic [31:0]      Ext_DataAdr,
    output logic [31:0]      Ext_WriteData,
    output logic             cpu_reset,
    output logic             busy,
    output logic [ERR_W-1:0] err_cnt
);
    state_t      state_q, state_d;
    logic [7:0]  n_q;
    logic [31:0] addr_q;
    logic        accept;
    logic        asm_clear, asm_shift, asm_full;
    logic [31:0] asm_word;

    assign accept = in_valid && in_ready;

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .shift     (asm_shift),
        .din       (in_data),
        .full      (asm_full),
        .word_next (asm_word)
    );

    always_comb begin
        state_d   = state_q;
        asm_clear = 1'b0;
        asm_shift = 1'b0;
        case (state_q)
            IDLE: begin
                asm_clear = 1'b1;
                if (accept) begin
                    if (in_data == HDR_LOAD)     state_d = CNT;
                    else if (in_data == HDR_RUN) state_d = RUNNING;
                end
            end
            CNT: if (accept) state_d = ADDR;
            ADDR: begin
                if (accept) begin
                    asm_shift = 1'b1;
                    if (asm_full) state_d = (n_q == 8'd0) ? IDLE : DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    asm_shift = 1'b1;
                    if (asm_full) state_d = WRITE;
                end
            end
            WRITE:   state_d = (n_q == 8'd1) ? IDLE : DATA;
            RUNNING: if (accept && in_data == CMD_HALT) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            n_q           <= 8'd0;
            addr_q        <= 32'd0;
            err_cnt       <= '0;
            Ext_MemWrite  <= 1'b0;
            Ext_DataAdr   <= 32'd0;
            Ext_WriteData <= 32'd0;
            cpu_reset     <= 1'b1;
            busy          <= 1'b0;
            in_ready      <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == CNT && accept)
                n_q <= in_data;
            if (state_q == ADDR && accept && asm_full)
                addr_q <= {asm_word[31:2], 2'b00};
            if (state_q == WRITE) begin
                addr_q <= addr_q + 32'd4;
                n_q    <= n_q - 8'd1;
            end
            // Unknown header bytes in IDLE are dropped and counted, saturating.
            if (state_q == IDLE && accept && in_data != HDR_LOAD && in_data != HDR_RUN
                && err_cnt != {ERR_W{1'b1}})
                err_cnt <= err_cnt + ERR_W'(1);

            // Outputs are registered from the next state so they line up with it.
            Ext_MemWrite <= (state_d == WRITE);
            if (state_d == WRITE) begin
                Ext_DataAdr   <= addr_q;
                Ext_WriteData <= asm_word;
            end
            cpu_reset <= (state_d != RUNNING);
            busy      <= state_busy(state_d);
            in_ready  <= (state_d != WRITE);
        end
    end

endmodule

// File: tb/tb_ext_mem_loader.sv
// Randomized frame-level bench for ext_mem_loader with a write scoreboard and error-count model.
module tb_ext_mem_loader;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        Ext_MemWrite;
    logic [31:0] Ext_DataAdr;
    logic [31:0] Ext_WriteData;
    logic        cpu_reset;
    logic        busy;
    logic [7:0]  err_cnt;

    ext_mem_loader #(.ERR_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .Ext_MemWrite  (Ext_MemWrite),
        .Ext_DataAdr   (Ext_DataAdr),
        .Ext_WriteData (Ext_WriteData),
        .cpu_reset     (cpu_reset),
        .busy          (busy),
        .err_cnt       (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         got_q[$];
    logic [31:0] wbuf[0:255];
    int          checks   = 0;
    int          failures = 0;
    int          err_exp  = 0;
    int          rdy_low  = 0;
    bit          mon_en   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Strobe capture and ready/strobe relationship, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (Ext_MemWrite === 1'b1) begin
                got_q.push_back('{adr: Ext_DataAdr, dat: Ext_WriteData});
                chk("cpu_held_on_write", cpu_reset, 1);
            end
            if (in_ready === 1'b0) rdy_low++;
            chk("rdy_vs_strobe", in_ready, !Ext_MemWrite);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int   waited;
        logic rdy;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (1) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            waited++;
            if (waited > 20) begin
                chk("send_timeout", waited, 0);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_g(input logic [7:0] b, input bit gaps);
        if (gaps && $urandom_range(3, 0) == 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end
        send_byte(b);
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Load frame from wbuf[0..n-1]; expected writes follow from word-aligned base + 4*i.
    task automatic load_frame(input logic [31:0] addr, input int n, input bit gaps);
        logic [31:0] base;
        logic [7:0]  nb;
        base = {addr[31:2], 2'b00};
        nb   = n[7:0];
        for (int w = 0; w < n; w++)
            exp_q.push_back('{adr: base + 32'(4 * w), dat: wbuf[w]});
        send_g(8'hA5, gaps);
        send_g(nb, gaps);
        for (int i = 0; i < 4; i++) send_g(addr[8*i +: 8], gaps);
        for (int w = 0; w < n; w++)
            for (int i = 0; i < 4; i++) send_g(wbuf[w][8*i +: 8], gaps);
        go_idle();
    endtask

    task automatic compare_writes(input string tag);
        wr_t g, e;
        repeat (8) @(negedge clk);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_adr"}, g.adr, e.adr);
            chk({tag, "_dat"}, g.dat, e.dat);
        end
        got_q.delete();
        exp_q.delete();
        chk({tag, "_busy"}, busy, 0);
    endtask

    function automatic logic [7:0] bad_byte();
        logic [7:0] b;
        do b = 8'($urandom_range(255, 0)); while (b == 8'hA5 || b == 8'h5A);
        return b;
    endfunction

    task automatic send_bad(input logic [7:0] b, input bit gaps);
        send_g(b, gaps);
        if (err_exp < 255) err_exp++;
    endtask

    task automatic run_session(input int junk, input bit gaps);
        logic [7:0] b;
        send_g(8'h5A, gaps);
        @(negedge clk);
        chk("run_cpu_reset", cpu_reset, 0);
        chk("run_busy", busy, 0);
        for (int i = 0; i < junk; i++) begin
            do b = 8'($urandom_range(255, 0)); while (b == 8'hC3);
            send_g(b, gaps);
        end
        send_g(8'hC3, gaps);
        @(negedge clk);
        chk("halt_cpu_reset", cpu_reset, 1);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wr"},   Ext_MemWrite, 0);
        chk({tag, "_adr"},  Ext_DataAdr, 0);
        chk({tag, "_dat"},  Ext_WriteData, 0);
        chk({tag, "_cpu"},  cpu_reset, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"},  err_cnt, 0);
        chk({tag, "_rdy"},  in_ready, 1);
    endtask

    initial begin
        int rl0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        reset  = 1'b0;
        mon_en = 1'b1;

        // Sum preload: N at 0x02000000 followed by Sum and CPU_Done.
        wbuf[0] = 32'd20; wbuf[1] = 32'd0; wbuf[2] = 32'd0;
        load_frame(32'h0200_0000, 3, 1'b0);
        compare_writes("sum");
        chk("sum_cpu", cpu_reset, 1);

        load_frame($urandom, 0, 1'b1);
        compare_writes("n0");

        wbuf[0] = $urandom; wbuf[1] = $urandom;
        load_frame(32'hFFFF_FFFE, 2, 1'b0);
        compare_writes("wrap");

        send_bad(8'h00, 1'b0); send_bad(8'hFF, 1'b0); send_bad(8'h3C, 1'b0);
        go_idle();
        @(negedge clk);
        chk("err3", err_cnt, 3);
        compare_writes("err3");
        for (int i = 0; i < 300; i++) send_bad(bad_byte(), 1'b0);
        go_idle();
        @(negedge clk);
        chk("err_sat", err_cnt, err_exp);

        // Run with load-like bytes that must be ignored.
        send_byte(8'h5A);
        @(negedge clk);
        chk("run_cpu_reset0", cpu_reset, 0);
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'hC3);
        @(negedge clk);
        chk("halt_cpu_reset1", cpu_reset, 1);
        in_valid = 1'b0;
        chk("run_err_unchanged", err_cnt, err_exp);
        compare_writes("run");

        // in_valid stays high across write cycles.
        for (int w = 0; w < 4; w++) wbuf[w] = $urandom;
        rl0 = rdy_low;
        load_frame($urandom, 4, 1'b0);
        compare_writes("bp");
        chk("bp_rdy_low", rdy_low - rl0, 4);

        // Reset in the middle of a word.
        send_byte(8'hA5);
        send_byte(8'h02);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(255, 0)));
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge clk);
        chk("mid_busy", busy, 1);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        reset   = 1'b0;
        err_exp = 0;
        got_q.delete();
        wbuf[0] = $urandom; wbuf[1] = $urandom;
        load_frame(32'h0000_1000, 2, 1'b0);
        compare_writes("after_rst");

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(2, 0))
                0: begin
                    int n;
                    n = $urandom_range(5, 0);
                    for (int w = 0; w < n; w++) wbuf[w] = $urandom;
                    load_frame($urandom, n, 1'b1);
                end
                1: begin
                    repeat ($urandom_range(3, 1)) send_bad(bad_byte(), 1'b1);
                    go_idle();
                end
                default: run_session($urandom_range(4, 0), 1'b1);
            endcase
            compare_writes("rnd");
            chk("rnd_err", err_cnt, err_exp);
            chk("rnd_cpu", cpu_reset, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
